// File: rtl/bnn_apb_csr.sv
// APB3 control/status register file for the BNN accelerator: configuration readback,
// sticky completion flag with W1C and interrupt, error responses, fixed one-wait-state handshake.
module bnn_apb_csr #(
    parameter int          ROW_W   = 5,
    parameter int          COL_W   = 5,
    parameter int          BUF_AW  = 11,
    parameter int          BATCH_W = 6,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [31:0]        s_apb_paddr,
    input  logic               s_apb_psel,
    input  logic               s_apb_penable,
    input  logic               s_apb_pwrite,
    input  logic [31:0]        s_apb_pwdata,
    output logic               s_apb_pready,
    output logic [31:0]        s_apb_prdata,
    output logic               s_apb_pslverr,
    input  logic               busy,
    output logic               weight_transfer,
    output logic               systolic_start,
    output logic [ROW_W-1:0]   last_row,
    output logic [COL_W-1:0]   last_col,
    output logic [BUF_AW-1:0]  activations_addr_start,
    output logic [BUF_AW-1:0]  partialsums_addr_start,
    output logic [BATCH_W-1:0] batch,
    output logic               accumulate,
    output logic               irq,
    output logic               o_dbg_state
);

    // APB handshake: a transfer commits on the first ACCESS cycle (psel & penable) seen in
    // IDLE; the RESP state then drives pready=1 for exactly one cycle with registered
    // prdata/pslverr, which are held at 0 whenever pready=0.
    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t               r_state;
    logic                 r_pready;
    logic [31:0]          r_prdata;
    logic                 r_pslverr;
    logic                 r_wt;
    logic                 r_ss;
    logic [ROW_W-1:0]     r_last_row;
    logic [COL_W-1:0]     r_last_col;
    logic [BUF_AW-1:0]    r_act_addr;
    logic [BUF_AW-1:0]    r_psum_addr;
    logic [BATCH_W-1:0]   r_batch;
    logic                 r_accum;
    logic                 r_irq_en;
    logic                 r_done;
    logic                 r_busy_d;

    logic [3:0]           w_idx;
    logic                 w_commit;
    logic                 w_err;
    logic [31:0]          w_rd_data;
    logic                 w_w1c;

    assign w_idx    = s_apb_paddr[5:2];
    assign w_commit = (r_state == IDLE) && s_apb_psel && s_apb_penable;
    assign w_w1c    = w_commit && s_apb_pwrite && (w_idx == 4'd7) && s_apb_pwdata[1];

    always_comb begin
        w_err     = 1'b0;
        w_rd_data = 32'd0;
        case (w_idx)
            4'd0: w_err = !s_apb_pwrite || (busy && s_apb_pwdata[1]);
            4'd1: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_last_row);  end
            4'd2: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_last_col);  end
            4'd3: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_act_addr);  end
            4'd4: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_batch);     end
            4'd5: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_psum_addr); end
            4'd6: begin w_err = s_apb_pwrite && busy; w_rd_data = 32'(r_accum);     end
            4'd7: w_rd_data = {30'd0, r_done, busy};
            4'd8: w_rd_data = 32'(r_irq_en);
            4'd9: begin w_err = s_apb_pwrite; w_rd_data = VERSION; end
            default: w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_pready    <= 1'b0;
            r_prdata    <= 32'd0;
            r_pslverr   <= 1'b0;
            r_wt        <= 1'b0;
            r_ss        <= 1'b0;
            r_last_row  <= '0;
            r_last_col  <= '0;
            r_act_addr  <= '0;
            r_psum_addr <= '0;
            r_batch     <= '0;
            r_accum     <= 1'b0;
            r_irq_en    <= 1'b0;
            r_done      <= 1'b0;
            r_busy_d    <= 1'b0;
        end else begin
            r_busy_d <= busy;
            r_wt     <= 1'b0;
            r_ss     <= 1'b0;
            // A busy falling edge takes priority over a simultaneous W1C clear.
            if (r_busy_d && !busy) begin
                r_done <= 1'b1;
            end else if (w_w1c) begin
                r_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_commit) begin
                        r_state   <= RESP;
                        r_pready  <= 1'b1;
                        r_pslverr <= w_err;
                        r_prdata  <= (!s_apb_pwrite && !w_err) ? w_rd_data : 32'd0;
                        if (s_apb_pwrite && !w_err) begin
                            case (w_idx)
                                4'd0: begin
                                    r_wt <= s_apb_pwdata[0];
                                    r_ss <= s_apb_pwdata[1];
                                end
                                4'd1: r_last_row  <= s_apb_pwdata[ROW_W-1:0];
                                4'd2: r_last_col  <= s_apb_pwdata[COL_W-1:0];
                                4'd3: r_act_addr  <= s_apb_pwdata[BUF_AW-1:0];
                                4'd4: r_batch     <= s_apb_pwdata[BATCH_W-1:0];
                                4'd5: r_psum_addr <= s_apb_pwdata[BUF_AW-1:0];
                                4'd6: r_accum     <= s_apb_pwdata[0];
                                4'd8: r_irq_en    <= s_apb_pwdata[0];
                                default: ;
                            endcase
                        end
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= 32'd0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_apb_pready           = r_pready;
    assign s_apb_prdata           = r_prdata;
    assign s_apb_pslverr          = r_pslverr;
    assign weight_transfer        = r_wt;
    assign systolic_start         = r_ss;
    assign last_row               = r_last_row;
    assign last_col               = r_last_col;
    assign activations_addr_start = r_act_addr;
    assign partialsums_addr_start = r_psum_addr;
    assign batch                  = r_batch;
    assign accumulate             = r_accum;
    assign irq                    = r_done & r_irq_en;
    assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_bnn_apb_csr.sv
// Directed bench for bnn_apb_csr: register map, command pulses, busy rules, done/irq,
// error responses, back-to-back transfers and reset during a transfer.
module tb_bnn_apb_csr;

    localparam logic [31:0] VERSION = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] paddr = '0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        busy = 1'b0;
    logic        weight_transfer;
    logic        systolic_start;
    logic [4:0]  last_row;
    logic [4:0]  last_col;
    logic [10:0] act_addr;
    logic [10:0] psum_addr;
    logic [5:0]  batch;
    logic        accumulate;
    logic        irq;
    logic        dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int wt_cnt = 0;
    int ss_cnt = 0;
    int pr_cnt = 0;
    int idle_bad = 0;
    logic p_wt;
    logic p_ss;

    bnn_apb_csr dut (
        .clk(clk), .resetn(resetn),
        .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
        .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pready(pready), .s_apb_prdata(prdata), .s_apb_pslverr(pslverr),
        .busy(busy), .weight_transfer(weight_transfer), .systolic_start(systolic_start),
        .last_row(last_row), .last_col(last_col),
        .activations_addr_start(act_addr), .partialsums_addr_start(psum_addr),
        .batch(batch), .accumulate(accumulate), .irq(irq), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (weight_transfer) wt_cnt++;
        if (systolic_start) ss_cnt++;
        if (pready) pr_cnt++;
        if (!pready && (prdata !== 32'd0 || pslverr !== 1'b0)) idle_bad++;
    end

    // Called just after a rising edge; returns just after the edge ending the pready cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int waits);
        logic got;
        got = 1'b0; rdata = '0; err = 1'b1; waits = 0;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1 penable = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (pready) begin
                got = 1'b1; rdata = prdata; err = pslverr;
                p_wt = weight_transfer; p_ss = systolic_start;
            end else begin
                waits++;
            end
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL timeout addr=%h: no pready within 8 cycles", addr);
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic err; int w; logic [31:0] exp;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (pready !== 1'b0 || prdata !== 32'd0 || pslverr !== 1'b0 || irq !== 1'b0 ||
            weight_transfer !== 1'b0 || systolic_start !== 1'b0 || last_row !== 5'd0 ||
            psum_addr !== 11'd0 || dbg_state !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: pready=%b prdata=%h pslverr=%b irq=%b row=%h st=%b, required all 0",
                     pready, prdata, pslverr, irq, last_row, dbg_state);
        end
        @(posedge clk); #1 resetn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            exp = (i == 9) ? VERSION : 32'd0;
            apb_xfer(1'b0, 32'(i * 4), 32'd0, rd, err, w);
            vectors++;
            if (rd !== exp || err !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_read off=%h: got %h err=%b, required %h err=0", i * 4, rd, err, exp);
            end
        end
        apb_xfer(1'b0, 32'h00, 32'd0, rd, err, w);
        vectors++;
        if (err !== 1'b1 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL read_cmd: got %h err=%b, required 0 err=1", rd, err);
        end
    endtask

    task automatic test_rw();
        logic [31:0] rd; logic err; int w;
        logic [31:0] addrs [6] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18};
        logic [31:0] wd    [6] = '{32'h1F, 32'h15, 32'h7FF, 32'h3F, 32'h123, 32'h1};
        for (int i = 0; i < 6; i++) begin
            apb_xfer(1'b1, addrs[i], wd[i], rd, err, w);
            vectors++;
            if (err !== 1'b0 || w !== 1) begin
                miscompares++;
                $display("FAIL write off=%h: err=%b waits=%0d, required err=0 waits=1", addrs[i], err, w);
            end
        end
        for (int i = 0; i < 6; i++) begin
            apb_xfer(1'b0, addrs[i], 32'd0, rd, err, w);
            vectors++;
            if (rd !== wd[i] || err !== 1'b0 || w !== 1) begin
                miscompares++;
                $display("FAIL readback off=%h: got %h err=%b waits=%0d, required %h err=0 waits=1",
                         addrs[i], rd, err, w, wd[i]);
            end
        end
        vectors++;
        if (last_row !== 5'h1F || last_col !== 5'h15 || act_addr !== 11'h7FF || batch !== 6'h3F ||
            psum_addr !== 11'h123 || accumulate !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_ports: row=%h col=%h act=%h batch=%h psum=%h acc=%b, required 1f 15 7ff 3f 123 1",
                     last_row, last_col, act_addr, batch, psum_addr, accumulate);
        end
        apb_xfer(1'b1, 32'h0C, 32'hFFFFF, rd, err, w);
        apb_xfer(1'b0, 32'h0C, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h7FF) begin
            miscompares++;
            $display("FAIL truncation: got %h, required 000007ff", rd);
        end
        apb_xfer(1'b0, 32'hFFFF_FF04, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h1F || err !== 1'b0) begin
            miscompares++;
            $display("FAIL high_addr_ignored: got %h err=%b, required 0000001f err=0", rd, err);
        end
    endtask

    task automatic test_cmd();
        logic [31:0] rd; logic err; int w;
        wt_cnt = 0; ss_cnt = 0;
        apb_xfer(1'b1, 32'h00, 32'h3, rd, err, w);
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b0 || p_wt !== 1'b1 || p_ss !== 1'b1 || wt_cnt !== 1 || ss_cnt !== 1) begin
            miscompares++;
            $display("FAIL cmd_pulse: err=%b at_pready wt=%b ss=%b cycles wt=%0d ss=%0d, required 0 1 1 1 1",
                     err, p_wt, p_ss, wt_cnt, ss_cnt);
        end
        busy = 1'b1;
        wt_cnt = 0; ss_cnt = 0;
        apb_xfer(1'b1, 32'h00, 32'h2, rd, err, w);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (err !== 1'b1 || wt_cnt !== 0 || ss_cnt !== 0) begin
            miscompares++;
            $display("FAIL cmd_busy: err=%b pulses wt=%0d ss=%0d, required err=1 0 0", err, wt_cnt, ss_cnt);
        end
    endtask

    task automatic test_busy_done();
        logic [31:0] rd; logic err; int w;
        apb_xfer(1'b1, 32'h08, 32'h7, rd, err, w);
        vectors++;
        if (err !== 1'b1 || last_col !== 5'h15) begin
            miscompares++;
            $display("FAIL busy_write: err=%b last_col=%h, required err=1 15", err, last_col);
        end
        apb_xfer(1'b0, 32'h1C, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h1) begin
            miscompares++;
            $display("FAIL status_busy: got %h, required 00000001", rd);
        end
        apb_xfer(1'b1, 32'h20, 32'h1, rd, err, w);
        busy = 1'b0;
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_early: got %b, required 0", irq);
        end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_set: got %b, required 1", irq);
        end
        @(posedge clk); #1;
        apb_xfer(1'b0, 32'h1C, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h2) begin
            miscompares++;
            $display("FAIL status_done: got %h, required 00000002", rd);
        end
        apb_xfer(1'b1, 32'h1C, 32'h2, rd, err, w);
        apb_xfer(1'b0, 32'h1C, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL w1c_clear: status=%h irq=%b, required 0 0", rd, irq);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] rd; logic err; int w;
        busy = 1'b1;
        @(posedge clk); #1;
        fork
            apb_xfer(1'b1, 32'h1C, 32'h2, rd, err, w);
            begin @(posedge clk); #2 busy = 1'b0; end
        join
        apb_xfer(1'b0, 32'h1C, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'h2 || irq !== 1'b1) begin
            miscompares++;
            $display("FAIL w1c_race: status=%h irq=%b, required 00000002 1", rd, irq);
        end
        apb_xfer(1'b1, 32'h1C, 32'h2, rd, err, w);
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int w;
        apb_xfer(1'b0, 32'h30, 32'd0, rd, err, w);
        vectors++;
        if (err !== 1'b1 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL unmapped_read: got %h err=%b, required 0 err=1", rd, err);
        end
        apb_xfer(1'b1, 32'h30, 32'hFFFF_FFFF, rd, err, w);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL unmapped_write: err=%b, required 1", err);
        end
        apb_xfer(1'b1, 32'h24, 32'h1234, rd, err, w);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL id_write: err=%b, required 1", err);
        end
        apb_xfer(1'b0, 32'h24, 32'd0, rd, err, w);
        vectors++;
        if (rd !== VERSION) begin
            miscompares++;
            $display("FAIL id_read: got %h, required %h", rd, VERSION);
        end
        pr_cnt = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h3;
        repeat (3) @(posedge clk);
        #1 psel = 1'b0;
        vectors++;
        if (pr_cnt !== 0 || last_row !== 5'h1F || last_col !== 5'h15 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL no_side_effect: pready_cycles=%0d row=%h col=%h irq=%b, required 0 1f 15 0",
                     pr_cnt, last_row, last_col, irq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd1, rd2; logic err; int w;
        pr_cnt = 0;
        apb_xfer(1'b1, 32'h04, 32'h0A, rd1, err, w);
        apb_xfer(1'b1, 32'h10, 32'h15, rd1, err, w);
        apb_xfer(1'b0, 32'h04, 32'd0, rd1, err, w);
        apb_xfer(1'b0, 32'h10, 32'd0, rd2, err, w);
        vectors++;
        if (rd1 !== 32'h0A || rd2 !== 32'h15 || pr_cnt !== 4) begin
            miscompares++;
            $display("FAIL back_to_back: rd=%h,%h pready_cycles=%0d, required 0000000a,00000015 4",
                     rd1, rd2, pr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int w;
        pr_cnt = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14; pwdata = 32'h55;
        @(posedge clk); #1 penable = 1'b1; resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (pr_cnt !== 0 || psum_addr !== 11'd0 || last_row !== 5'd0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: pready_cycles=%0d psum=%h row=%h irq=%b, required 0 0 0 0",
                     pr_cnt, psum_addr, last_row, irq);
        end
        apb_xfer(1'b0, 32'h14, 32'd0, rd, err, w);
        vectors++;
        if (rd !== 32'd0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_read: got %h err=%b, required 0 err=0", rd, err);
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_cmd();
        test_busy_done();
        test_w1c_race();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        vectors++;
        if (idle_bad !== 0) begin
            miscompares++;
            $display("FAIL idle_outputs: %0d cycles with nonzero prdata/pslverr while pready=0, required 0", idle_bad);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
